// File: rtl/reg_read_stage_pkg.sv
// Shared types and constants for the register read stage and its scoreboard.
package reg_read_stage_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker; flags ops whose sources or destination
// still have a writeback outstanding.
module reg_scoreboard
  import reg_read_stage_pkg::*;
#(
  parameter  int unsigned n_regs_p  = 32,
  localparam int unsigned wd_addr_p = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [wd_addr_p-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [wd_addr_p-1:0] clr_addr,
  input  logic [wd_addr_p-1:0] rs1_addr,
  input  logic [wd_addr_p-1:0] rs2_addr,
  input  logic [wd_addr_p-1:0] rd_addr,
  input  logic                 rd_we,
  output logic                 hazard
);

  localparam logic [wd_addr_p-1:0] zero_addr = wd_addr_p'(REG_ZERO);
  localparam logic [n_regs_p-1:0]  one_hot0  = {{(n_regs_p-1){1'b0}}, 1'b1};

  logic [n_regs_p-1:0] pending_r;
  logic [n_regs_p-1:0] set_mask_s;
  logic [n_regs_p-1:0] clr_mask_s;
  logic [n_regs_p-1:0] pending_nxt_s;
  logic                rs1_busy_s;
  logic                rs2_busy_s;
  logic                rd_busy_s;

  // A writeback arriving this cycle resolves the wait, so it masks the pending bit.
  assign rs1_busy_s = (rs1_addr != zero_addr) && pending_r[rs1_addr]
                      && !(clr_en && (clr_addr == rs1_addr));
  assign rs2_busy_s = (rs2_addr != zero_addr) && pending_r[rs2_addr]
                      && !(clr_en && (clr_addr == rs2_addr));
  assign rd_busy_s  = rd_we && (rd_addr != zero_addr) && pending_r[rd_addr]
                      && !(clr_en && (clr_addr == rd_addr));
  assign hazard     = rs1_busy_s || rs2_busy_s || rd_busy_s;

  // Next pending vector: set is OR-ed after clear so a new owner wins.
  always_comb begin
    set_mask_s    = (set_en && (set_addr != zero_addr)) ? (one_hot0 << set_addr) : '0;
    clr_mask_s    = (clr_en && (clr_addr != zero_addr)) ? (one_hot0 << clr_addr) : '0;
    pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Read-operand stage: register array with writeback port, bypassed operand reads,
// hazard stall via reg_scoreboard and a single valid/ready output register.
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter  int unsigned wd_regs_p = 32,
  parameter  int unsigned n_regs_p  = 32,
  localparam int unsigned wd_addr_p = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [wd_addr_p-1:0] i_rs1_addr,
  input  logic [wd_addr_p-1:0] i_rs2_addr,
  input  logic [wd_addr_p-1:0] i_rd_addr,
  input  logic                 i_rd_we,
  input  logic                 i_wr_en,
  input  logic [wd_addr_p-1:0] i_wr_addr,
  input  logic [wd_regs_p-1:0] i_wr_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [wd_regs_p-1:0] o_rs1_data,
  output logic [wd_regs_p-1:0] o_rs2_data,
  output logic [wd_addr_p-1:0] o_rd_addr,
  output logic                 o_rd_we
);

  localparam logic [wd_addr_p-1:0] zero_addr = wd_addr_p'(REG_ZERO);

  logic [wd_regs_p-1:0] array_r [n_regs_p];
  logic [wd_regs_p-1:0] rs1_data_s;
  logic [wd_regs_p-1:0] rs2_data_s;
  logic                 hazard_s;
  logic                 issue_s;

  reg_scoreboard #(
    .n_regs_p (n_regs_p)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_s && i_rd_we),
    .set_addr (i_rd_addr),
    .clr_en   (i_wr_en),
    .clr_addr (i_wr_addr),
    .rs1_addr (i_rs1_addr),
    .rs2_addr (i_rs2_addr),
    .rd_addr  (i_rd_addr),
    .rd_we    (i_rd_we),
    .hazard   (hazard_s)
  );

  // x0 reads as zero; a same-cycle writeback is forwarded ahead of the array.
  assign rs1_data_s = (i_rs1_addr == zero_addr) ? '0
                    : (i_wr_en && (i_wr_addr == i_rs1_addr)) ? i_wr_data
                    : array_r[i_rs1_addr];
  assign rs2_data_s = (i_rs2_addr == zero_addr) ? '0
                    : (i_wr_en && (i_wr_addr == i_rs2_addr)) ? i_wr_data
                    : array_r[i_rs2_addr];

  assign o_ready = (!o_valid || i_ready) && !hazard_s;
  assign issue_s = i_valid && o_ready;

  // Architectural register array; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < n_regs_p; i++) begin
        array_r[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != zero_addr)) begin
      array_r[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register: capture on issue, drop valid on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_rd_addr  <= '0;
      o_rd_we    <= 1'b0;
    end else if (issue_s) begin
      o_valid    <= 1'b1;
      o_rs1_data <= rs1_data_s;
      o_rs2_data <= rs2_data_s;
      o_rd_addr  <= i_rd_addr;
      o_rd_we    <= i_rd_we;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule
